// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the IF/ID decoupling buffer.
// A packet is the {pc, pc4, instr} triple that IF hands to ID.
package if_id_buffer_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int          IF_ID_DEPTH = 2;
    localparam int          IF_PKT_W    = 96;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_pkt_t;

    // Packet presented to ID while the buffer is empty.
    function automatic if_pkt_t empty_pkt();
        if_pkt_t p;
        p.pc    = 32'h0;
        p.pc4   = 32'h0;
        p.instr = NOP_INSTR;
        return p;
    endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Handshake bundle between IF, the IF/ID buffer and ID.
// The buffer takes the slave view; the surrounding pipeline takes the master view.
interface if_id_buffer_if #(
    parameter int PTR_W = 1
);
    logic              in_valid;
    logic [31:0]       in_pc;
    logic [31:0]       in_pc4;
    logic [31:0]       in_instr;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc4;
    logic [31:0]       out_instr;
    logic              flush;
    logic [PTR_W:0]    count;

    modport slave (
        input  in_valid, in_pc, in_pc4, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_pc4, out_instr, count
    );

    modport master (
        output in_valid, in_pc, in_pc4, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_pc4, out_instr, count
    );
endinterface

// File: rtl/if_id_buffer_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for a small power-of-two FIFO.
// Reusable by any decoupling buffer that keeps its own storage array.
module fifo_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);
    logic push_ok;
    logic pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // Guard here too so a careless caller can never over- or under-run the count.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)
                count <= count + (PTR_W+1)'(1);
            else if (pop_ok && !push_ok)
                count <= count - (PTR_W+1)'(1);
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count <= (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: buffers fetched packets, back-pressures the PC via
// in_ready, and drops everything in one cycle on a redirect flush.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = IF_ID_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    if_id_buffer_if.slave  bus
);
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    if_pkt_t          mem [DEPTH];
    if_pkt_t          head;
    if_pkt_t          in_pkt;

    // in_ready looks only at occupancy, so a full buffer never passes through.
    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign push = bus.in_valid & ~full & ~bus.flush;
    assign pop  = ~empty & bus.out_ready & ~bus.flush;

    fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (bus.flush),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign bus.count = count;

    always_comb begin
        in_pkt.pc    = bus.in_pc;
        in_pkt.pc4   = bus.in_pc4;
        in_pkt.instr = bus.in_instr;
    end

    // Storage carries data only; it is never reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_pkt;
    end

    always_comb begin
        head = empty_pkt();
        if (!empty) head = mem[rd_ptr];
    end

    assign bus.out_pc    = head.pc;
    assign bus.out_pc4   = head.pc4;
    assign bus.out_instr = head.instr;

endmodule
